// File: rtl/inst_loader_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_loader_ctrl_pkg : shared states and sizing helpers for the loader    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package inst_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    START = 3'd4,
    RUN   = 3'd5,
    ERR   = 3'd6
  } loader_state_t;

  localparam int HDR_BYTES = 4;

  function automatic int inst_bytes(input int width);
    return width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_loader_ctrl_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_word_assembler : big-endian byte-to-word shift register + counter    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module byte_word_assembler
  import inst_loader_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_done
);

  localparam int c_nbytes = inst_bytes(WIDTH);
  localparam int c_cnt_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_last;

  // word/word_done include the byte being accepted this cycle
  assign w_last    = byte_valid && (r_cnt == c_cnt_w'(c_nbytes - 1));
  assign word_done = w_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (byte_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  generate
    if (WIDTH > 8) begin : g_wide
      logic [WIDTH-9:0] r_shift;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_shift <= '0;
        end else if (byte_valid) begin
          r_shift <= (WIDTH-8)'({r_shift, byte_in});
        end
      end
      assign word = {r_shift, byte_in};
    end else begin : g_narrow
      assign word = byte_in;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/inst_loader_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_loader_ctrl : loads instruction memory from a UART byte stream,      |
// | then resets the PC and releases the core.                      Rev 1.0    |
// +--------------------------------------------------------------------------+
module inst_loader_ctrl
  import inst_loader_ctrl_pkg::*;
#(
  parameter int INST_WIDTH     = 32,
  parameter int INST_MEM_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  core_stall,
  input  logic                  core_halt,
  output logic [INST_WIDTH-1:0] prog_data,
  output logic                  prog_we,
  output logic                  pc_reset,
  output logic                  fetch_stall,
  output logic                  core_run,
  output logic                  load_err,
  output logic [31:0]           words_left
);

  localparam logic [32:0] c_capacity = 33'd1 << INST_MEM_WIDTH;

  loader_state_t          r_state;
  logic                   w_accept;
  logic [31:0]            w_hdr_word;
  logic                   w_hdr_done;
  logic [INST_WIDTH-1:0]  w_data_word;
  logic                   w_data_done;

  assign w_accept = rx_valid & rx_ready;

  // Holding clear outside the owning state resets the byte count on entry.
  byte_word_assembler #(.WIDTH(HDR_BYTES * 8)) u_hdr_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (r_state != HDR),
    .byte_in    (rx_data),
    .byte_valid (w_accept && (r_state == HDR)),
    .word       (w_hdr_word),
    .word_done  (w_hdr_done)
  );

  byte_word_assembler #(.WIDTH(INST_WIDTH)) u_data_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (r_state != DATA),
    .byte_in    (rx_data),
    .byte_valid (w_accept && (r_state == DATA)),
    .word       (w_data_word),
    .word_done  (w_data_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= INIT;
      pc_reset    <= 1'b1;
      fetch_stall <= 1'b1;
      prog_we     <= 1'b0;
      core_run    <= 1'b0;
      rx_ready    <= 1'b0;
      load_err    <= 1'b0;
      words_left  <= '0;
      prog_data   <= '0;
    end else begin
      prog_we  <= 1'b0;
      pc_reset <= 1'b0;
      case (r_state)
        INIT: begin
          r_state     <= HDR;
          rx_ready    <= 1'b1;
          fetch_stall <= 1'b1;
        end
        HDR: begin
          if (w_hdr_done) begin
            if (w_hdr_word == 32'd0) begin
              r_state  <= START;
              rx_ready <= 1'b0;
              pc_reset <= 1'b1;
            end else if ({1'b0, w_hdr_word} > c_capacity) begin
              r_state  <= ERR;
              load_err <= 1'b1;
            end else begin
              r_state    <= DATA;
              words_left <= w_hdr_word;
            end
          end
        end
        DATA: begin
          if (w_data_done) begin
            r_state     <= WRITE;
            prog_data   <= w_data_word;
            prog_we     <= 1'b1;
            fetch_stall <= 1'b0;
            rx_ready    <= 1'b0;
            words_left  <= words_left - 32'd1;
          end
        end
        WRITE: begin
          fetch_stall <= 1'b1;
          if (words_left == 32'd0) begin
            r_state  <= START;
            pc_reset <= 1'b1;
          end else begin
            r_state  <= DATA;
            rx_ready <= 1'b1;
          end
        end
        START: begin
          r_state     <= RUN;
          core_run    <= 1'b1;
          fetch_stall <= 1'b0;
        end
        RUN: begin
          if (core_halt) begin
            r_state     <= INIT;
            core_run    <= 1'b0;
            pc_reset    <= 1'b1;
            fetch_stall <= 1'b1;
          end else begin
            fetch_stall <= core_stall;
          end
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state     <= INIT;
          pc_reset    <= 1'b1;
          fetch_stall <= 1'b1;
          rx_ready    <= 1'b0;
          core_run    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
